// File: rtl/cf_bank_mapper_pipe.sv
// cf_bank_mapper_pipe: splits LANES flat addresses into bank index and row
// using a run-time selectable swizzle, carried through a 2-stage valid/ready
// pipeline with an exhaustive intra-beat bank conflict flag.
// Optional feature macro: CFMAP_CONFLICT_CNT_EN (saturating conflict counter).
module cf_bank_mapper_pipe #(
   parameter int ADDR_W = 10,
   parameter int BANK_W = 4,
   parameter int LANES  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [1:0]                       cfg_mode,
   input  logic [LANES*ADDR_W-1:0]          in_addr,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES*BANK_W-1:0]          out_bank,
   output logic [LANES*(ADDR_W-BANK_W)-1:0] out_row,
   output logic                             out_conflict,
   output logic [1:0]                       out_mode,
   output logic [CNT_W-1:0]                 conflict_cnt
);

   localparam int ROW_W = ADDR_W - BANK_W;
   localparam int NCH   = (ADDR_W + BANK_W - 1) / BANK_W;

   // Mode 0 linear, 2 fold, 1 and reserved 3 flip the bank MSB by row parity.
   function automatic logic [BANK_W-1:0] map_bank(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        m);
      logic [NCH*BANK_W-1:0] ext;
      logic [BANK_W-1:0]     lo;
      logic [BANK_W-1:0]     fold;
      logic [BANK_W-1:0]     flip;
      ext               = '0;
      ext[ADDR_W-1:0]   = a;
      lo                = a[BANK_W-1:0];
      flip              = '0;
      flip[BANK_W-1]    = ^a[ADDR_W-1:BANK_W];
      fold              = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         fold = fold ^ ext[c*BANK_W +: BANK_W];
      end
      case (m)
         2'd0:    map_bank = lo;
         2'd2:    map_bank = fold;
         default: map_bank = lo ^ flip;
      endcase
   endfunction

   logic                     s1_valid_q, s2_valid_q;
   logic [LANES*BANK_W-1:0]  s1_bank_d, s1_bank_q, s2_bank_q;
   logic [LANES*ROW_W-1:0]   s1_row_d, s1_row_q, s2_row_q;
   logic [1:0]               s1_mode_q, s2_mode_q;
   logic                     s2_conflict_d, s2_conflict_q;
   logic                     s2_adv, s1_adv;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Per-lane bank/row mapping of the incoming beat.
   always_comb begin
      s1_bank_d = '0;
      s1_row_d  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         s1_bank_d[l*BANK_W +: BANK_W] = map_bank(in_addr[l*ADDR_W +: ADDR_W], cfg_mode);
         s1_row_d[l*ROW_W +: ROW_W]    = in_addr[l*ADDR_W + BANK_W +: ROW_W];
      end
   end

   // Exhaustive pairwise bank comparison over the S1 beat.
   always_comb begin
      s2_conflict_d = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         for (int unsigned j = i + 1; j < LANES; j++) begin
            if (s1_bank_q[i*BANK_W +: BANK_W] == s1_bank_q[j*BANK_W +: BANK_W]) begin
               s2_conflict_d = 1'b1;
            end
         end
      end
   end

   // Stage 1 register: loads on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_bank_q  <= '0;
         s1_row_q   <= '0;
         s1_mode_q  <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_bank_q <= s1_bank_d;
            s1_row_q  <= s1_row_d;
            s1_mode_q <= cfg_mode;
         end
      end
   end

   // Stage 2 register: holds the output beat while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q    <= 1'b0;
         s2_bank_q     <= '0;
         s2_row_q      <= '0;
         s2_mode_q     <= '0;
         s2_conflict_q <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_bank_q     <= s1_bank_q;
            s2_row_q      <= s1_row_q;
            s2_mode_q     <= s1_mode_q;
            s2_conflict_q <= s2_conflict_d;
         end
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_bank     = s2_bank_q;
   assign out_row      = s2_row_q;
   assign out_mode     = s2_mode_q;
   assign out_conflict = s2_conflict_q;

`ifdef CFMAP_CONFLICT_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of conflicting beats, counted at the output handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (s2_valid_q && out_ready && s2_conflict_q && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign conflict_cnt = cnt_q;
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cf_bank_mapper_pipe.sv
// Scoreboard bench for cf_bank_mapper_pipe (default parameters).
module tb_cf_bank_mapper_pipe;

`ifdef CFMAP_CONFLICT_CNT_EN
   localparam int CNT_W_TB = 2;
`else
   localparam int CNT_W_TB = 16;
`endif

   typedef struct {
      logic [63:0] bank;
      logic [95:0] row;
      logic        conf;
      logic [1:0]  mode;
      int          acc_cyc;
      bit          lat;
   } beat_t;

   logic                clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]          cfg_mode, out_mode;
   logic [159:0]        in_addr;
   logic [63:0]         out_bank;
   logic [95:0]         out_row;
   logic                out_conflict;
   logic [CNT_W_TB-1:0] conflict_cnt;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    exp_cnt  = 0;
   bit    lat_chk  = 1'b1;
   beat_t sb[$];

   cf_bank_mapper_pipe #(.ADDR_W(10), .BANK_W(4), .LANES(16), .CNT_W(CNT_W_TB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .cfg_mode(cfg_mode), .in_addr(in_addr), .out_valid(out_valid),
      .out_ready(out_ready), .out_bank(out_bank), .out_row(out_row),
      .out_conflict(out_conflict), .out_mode(out_mode), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Independent reference: per-lane swizzle plus a bank-occupancy histogram.
   function automatic beat_t model(input logic [1:0] m, input logic [159:0] a);
      beat_t      r;
      logic [9:0] ad;
      logic [3:0] b;
      logic [15:0] seen;
      r.bank = '0; r.row = '0; r.conf = 1'b0; r.mode = m; r.acc_cyc = 0; r.lat = 1'b0;
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         ad = a[i*10 +: 10];
         case (m)
            2'd0:    b = ad[3:0];
            2'd2:    b = ad[3:0] ^ ad[7:4] ^ {2'b00, ad[9:8]};
            default: b = {ad[3] ^ (^ad[9:4]), ad[2:0]};
         endcase
         if (seen[b]) r.conf = 1'b1;
         seen[b] = 1'b1;
         r.bank[i*4 +: 4] = b;
         r.row[i*6 +: 6]  = ad[9:4];
      end
      return r;
   endfunction

   // Monitor: mid-cycle, decide what the next rising edge will transfer.
   always @(negedge clk) begin
      beat_t e;
      if (!rst) begin
         check("conflict_cnt", conflict_cnt, exp_cnt);
         if (out_valid && sb.size() == 0) begin
            check("extra_beat", out_valid, 1'b0);
         end else if (out_valid) begin
            e = sb[0];
            check("out_bank", out_bank, e.bank);
            check("out_row", out_row, e.row);
            check("out_conflict", out_conflict, e.conf);
            check("out_mode", out_mode, e.mode);
            if (out_ready) begin
               void'(sb.pop_front());
               if (e.lat) check("latency", cyc - e.acc_cyc, 2);
               if (e.conf && exp_cnt < (1 << CNT_W_TB) - 1) begin
`ifdef CFMAP_CONFLICT_CNT_EN
                  exp_cnt++;
`endif
               end
            end
         end
         if (in_valid && in_ready) begin
            e = model(cfg_mode, in_addr);
            e.acc_cyc = cyc;
            e.lat = lat_chk;
            sb.push_back(e);
         end
      end
   end

   // Called at posedge+1; leaves in_valid high after the accepting edge.
   task automatic send(input logic [1:0] m, input logic [159:0] a);
      int budget;
      in_valid = 1'b1; cfg_mode = m; in_addr = a;
      budget = 40;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("accept_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_bank", out_bank, 64'h0);
      check("rst_out_row", out_row, 96'h0);
      check("rst_out_conflict", out_conflict, 1'b0);
      check("rst_out_mode", out_mode, 2'd0);
      check("rst_conflict_cnt", conflict_cnt, 0);
      sb.delete();
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic logic [159:0] rand_addr();
      logic [159:0] a;
      for (int i = 0; i < 16; i++) a[i*10 +: 10] = 10'($urandom_range(0, 1023));
      return a;
   endfunction

   logic [159:0] a1, a2, a3;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_mode = 2'd0; in_addr = '0;
      #1;
      check("init_out_valid", out_valid, 1'b0);
      check("init_out_bank", out_bank, 64'h0);
      check("init_out_row", out_row, 96'h0);
      check("init_conflict_cnt", conflict_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed beats from the test plan.
      for (int i = 0; i < 16; i++) a1[i*10 +: 10] = 10'(i);
      send(2'd1, a1);
      a2 = a1;
      a2[0 +: 10]  = 10'h000;
      a2[10 +: 10] = 10'h010;
      send(2'd0, a2);
      send(2'd1, a2);
      a2[80 +: 10] = 10'h018;
      send(2'd1, a2);
      a3 = rand_addr();
      a3[0 +: 10] = 10'h3FF;
      send(2'd2, a3);
      send(2'd3, a3);
      idle(4);

      // Random back-to-back beats, all modes.
      for (int k = 0; k < 24; k++) send(2'($urandom_range(0, 3)), rand_addr());
      idle(4);

      // Backpressure: 4 beats against a 5-cycle stall.
      lat_chk = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++) send(2'($urandom_range(0, 3)), rand_addr());
            in_valid = 1'b0;
         end
         begin
            repeat (3) begin @(posedge clk); #1; end
            check("full_in_ready", in_ready, 1'b0);
            check("full_out_valid", out_valid, 1'b1);
            check("full_depth", sb.size(), 2);
            repeat (2) begin @(posedge clk); #1; end
            out_ready = 1'b1;
         end
      join
      idle(5);
      check("bp_drain", sb.size(), 0);
      lat_chk = 1'b1;

      // Counter: first conflicting beat held before its handshake.
      do_reset();
      a2[80 +: 10] = 10'h008;
      lat_chk = 1'b0;
      out_ready = 1'b0;
      send(2'd0, a2);
      idle(4);
      out_ready = 1'b1;
      lat_chk = 1'b1;
      for (int k = 0; k < 4; k++) send(2'd0, a2);
      idle(5);
`ifdef CFMAP_CONFLICT_CNT_EN
      check("cnt_saturated", conflict_cnt, 3);
`endif

      // Reset with two beats in flight, then a fresh beat.
      out_ready = 1'b0;
      send(2'd0, a2);
      send(2'd1, rand_addr());
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1'b1);
      do_reset();
      out_ready = 1'b1;
      send(2'd2, rand_addr());
      idle(5);
      check("final_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
